// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives the shared-ALU datapath.
// It adds handshaked memory waits with a timeout, a synchronised IRQ and trapping of undefined instructions.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int IRQ_SYNC    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       IRQ,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [2:0] PCSrc,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] MemToReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [1:0] ALUOp,
  output logic       UndefinedInst,
  output logic       irq_ack,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_IRQ      = 4'd12,
    S_EXCEPT   = 4'd13
  } stateT;

  stateT               curState;
  logic [CNT_W-1:0]    waitCnt;
  logic [IRQ_SYNC-1:0] irqSync;
  logic                irqPrev;
  logic                irqPend;
  logic                busErrQ;

  logic isRType, isShift, isRAlu, isJr, isJalr, isJ, isJal;
  logic isIAlu, isLw, isSw, isBranch;
  logic memState, timeout, irqRise;

  assign isRType  = (OpCode == 6'h00);
  assign isShift  = isRType && (Funct inside {6'h00, 6'h02, 6'h03});
  assign isRAlu   = isShift || (isRType && (Funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                                          6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b}));
  assign isJr     = isRType && (Funct == 6'h08);
  assign isJalr   = isRType && (Funct == 6'h09);
  assign isJ      = (OpCode == 6'h02);
  assign isJal    = (OpCode == 6'h03);
  assign isIAlu   = OpCode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f};
  assign isLw     = (OpCode == 6'h23);
  assign isSw     = (OpCode == 6'h2b);
  assign isBranch = OpCode inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};

  assign UndefinedInst = !(isRAlu || isJr || isJalr || isJ || isJal ||
                           isIAlu || isLw || isSw || isBranch);

  // A memory state gives up only when the limit is reached and the ready still has not arrived.
  assign memState = curState inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign timeout  = (MEM_TIMEOUT != 0) && memState && !mem_ready &&
                    (waitCnt == CNT_W'(MEM_TIMEOUT));
  assign irqRise  = irqSync[IRQ_SYNC-1] && !irqPrev;

  assign bus_err = busErrQ;
  assign state   = curState;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState <= S_IDLE;
      waitCnt  <= '0;
      irqSync  <= '0;
      irqPrev  <= 1'b0;
      irqPend  <= 1'b0;
      busErrQ  <= 1'b0;
    end else begin
      irqSync[0] <= IRQ;
      for (int i = 1; i < IRQ_SYNC; i++) irqSync[i] <= irqSync[i-1];
      irqPrev <= irqSync[IRQ_SYNC-1];

      // A fresh edge wins over the clear so a request landing in the IRQ cycle is not lost.
      if (irqRise) irqPend <= 1'b1;
      else if (curState == S_IRQ) irqPend <= 1'b0;

      if (memState && !mem_ready && !timeout) waitCnt <= waitCnt + CNT_W'(1);
      else waitCnt <= '0;

      if (timeout) busErrQ <= 1'b1;

      case (curState)
        S_IDLE:   curState <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) curState <= S_DECODE;
          else if (timeout) curState <= S_EXCEPT;
        end
        S_DECODE: begin
          if (UndefinedInst) curState <= S_EXCEPT;
          else if (irqPend) curState <= S_IRQ;
          else if (isLw || isSw) curState <= S_MEM_ADDR;
          else if (isBranch) curState <= S_BRANCH;
          else if (isJ || isJal || isJr || isJalr) curState <= S_JUMP;
          else if (isRAlu) curState <= S_EXEC_R;
          else curState <= S_EXEC_I;
        end
        S_EXEC_R, S_EXEC_I: curState <= S_WB_ALU;
        S_MEM_ADDR: curState <= isLw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (mem_ready) curState <= S_WB_MEM;
          else if (timeout) curState <= S_EXCEPT;
        end
        S_MEM_WR: begin
          if (mem_ready) curState <= S_FETCH;
          else if (timeout) curState <= S_EXCEPT;
        end
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_IRQ, S_EXCEPT: curState <= S_FETCH;
        default:  curState <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the datapath controls; only FETCH looks at mem_ready to latch IR and PC.
  always_comb begin
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 3'b000;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    ALUOp       = 2'b00;
    irq_ack     = 1'b0;
    case (curState)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_EXEC_R: ALUSrcA = isShift ? 2'b10 : 2'b01;
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        ExtOp   = !(OpCode inside {6'h09, 6'h0b, 6'h0c, 6'h0d});
        LuOp    = (OpCode == 6'h0f);
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        RegDst   = isRType ? 2'b01 : 2'b00;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: MemRead = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 2'b01;
      end
      S_MEM_WR: MemWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 3'b001;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = (isJ || isJal) ? 3'b010 : 3'b011;
        if (isJal || isJalr) begin
          RegWrite = 1'b1;
          RegDst   = isJal ? 2'b10 : 2'b01;
          MemToReg = 2'b10;
        end
      end
      S_IRQ: begin
        PCWrite  = 1'b1;
        PCSrc    = 3'b100;
        RegWrite = 1'b1;
        RegDst   = 2'b11;
        MemToReg = 2'b10;
        irq_ack  = 1'b1;
      end
      S_EXCEPT: begin
        PCWrite = 1'b1;
        PCSrc   = 3'b101;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios then random instruction streams, each cycle
// compared against an instruction-level model of the expected control sequence.
module tb_multicycle_controller;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;
  localparam int IRQ_SYNC    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       IRQ, mem_ready;
  logic       IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, MemWrite;
  logic       ExtOp, LuOp, UndefinedInst, irq_ack, bus_err;
  logic [2:0] PCSrc;
  logic [1:0] RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W), .IRQ_SYNC(IRQ_SYNC)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .IRQ(IRQ), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .LuOp(LuOp),
    .ALUOp(ALUOp), .UndefinedInst(UndefinedInst), .irq_ack(irq_ack), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0, PH_FETCH = 4'd1, PH_DECODE = 4'd2, PH_EXEC_R = 4'd3, PH_EXEC_I = 4'd4,
    PH_WB_ALU = 4'd5, PH_MEM_ADDR = 4'd6, PH_MEM_RD = 4'd7, PH_WB_MEM = 4'd8, PH_MEM_WR = 4'd9,
    PH_BRANCH = 4'd10, PH_JUMP = 4'd11, PH_IRQ = 4'd12, PH_EXCEPT = 4'd13, PH_NONE = 4'd15
  } phaseT;

  typedef enum {C_UNDEF, C_RALU, C_IALU, C_LW, C_SW, C_BR, C_JMP} classT;

  typedef struct packed {
    logic       irw, pcw, pcwc;
    logic [2:0] pcsrc;
    logic       regw;
    logic [1:0] regdst;
    logic       memr, memw;
    logic [1:0] m2r, asa, asb;
    logic       ext, lu;
    logic [1:0] aluop;
    logic       ack;
  } ctlT;

  int    checkCount = 0;
  int    passCount  = 0;
  int    cycleNum   = 0;
  int    irqRaiseAt = -100;
  phaseT irqOnPhase = PH_NONE;
  logic  modelPend  = 1'b0;
  logic  modelBusErr = 1'b0;
  logic [5:0] curOp = 6'h00, curFunct = 6'h00;

  function automatic classT classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00: case (fn)
        6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2a, 6'h2b: return C_RALU;
        6'h08, 6'h09: return C_JMP;
        default: return C_UNDEF;
      endcase
      6'h02, 6'h03: return C_JMP;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return C_BR;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f: return C_IALU;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      default: return C_UNDEF;
    endcase
  endfunction

  // Control bundle each phase must present, written straight from the per-state control table.
  function automatic ctlT expectCtl(phaseT ph, logic rdy, logic [5:0] op, logic [5:0] fn);
    ctlT e = '0;
    case (ph)
      PH_FETCH: begin
        e.memr = 1'b1; e.asb = 2'b01; e.aluop = 2'b10;
        if (rdy) begin e.irw = 1'b1; e.pcw = 1'b1; end
      end
      PH_DECODE: e.asb = 2'b11;
      PH_EXEC_R: e.asa = (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) ? 2'b10 : 2'b01;
      PH_EXEC_I: begin
        e.asa = 2'b01; e.asb = 2'b10; e.aluop = 2'b11;
        e.ext = !(op == 6'h09 || op == 6'h0b || op == 6'h0c || op == 6'h0d);
        e.lu  = (op == 6'h0f);
      end
      PH_WB_ALU: begin e.regw = 1'b1; e.regdst = (op == 6'h00) ? 2'b01 : 2'b00; end
      PH_MEM_ADDR: begin e.asa = 2'b01; e.asb = 2'b10; e.aluop = 2'b10; e.ext = 1'b1; end
      PH_MEM_RD: e.memr = 1'b1;
      PH_WB_MEM: begin e.regw = 1'b1; e.m2r = 2'b01; end
      PH_MEM_WR: e.memw = 1'b1;
      PH_BRANCH: begin e.asa = 2'b01; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcsrc = 3'b001; end
      PH_JUMP: begin
        e.pcw = 1'b1;
        e.pcsrc = (op == 6'h02 || op == 6'h03) ? 3'b010 : 3'b011;
        if (op == 6'h03) begin e.regw = 1'b1; e.regdst = 2'b10; e.m2r = 2'b10; end
        if (op == 6'h00 && fn == 6'h09) begin e.regw = 1'b1; e.regdst = 2'b01; e.m2r = 2'b10; end
      end
      PH_IRQ: begin
        e.pcw = 1'b1; e.pcsrc = 3'b100; e.regw = 1'b1; e.regdst = 2'b11; e.m2r = 2'b10; e.ack = 1'b1;
      end
      PH_EXCEPT: begin e.pcw = 1'b1; e.pcsrc = 3'b101; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctlT obsCtl();
    return {IRWrite, PCWrite, PCWriteCond, PCSrc, RegWrite, RegDst, MemRead, MemWrite,
            MemToReg, ALUSrcA, ALUSrcB, ExtOp, LuOp, ALUOp, irq_ack};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNum);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ctl"}, 32'(obsCtl()), 32'h0);
    checkOutput({tag, "_state"}, 32'(state), 32'(PH_IDLE));
    checkOutput({tag, "_bus_err"}, 32'(bus_err), 32'h0);
  endtask

  // One clock cycle in the given phase: drive at the falling edge, compare shortly after.
  task automatic applyStimulus(input phaseT ph, input logic rdy);
    @(negedge clk);
    cycleNum++;
    OpCode = curOp; Funct = curFunct; mem_ready = rdy;
    if (ph == irqOnPhase) begin
      IRQ = 1'b1; irqRaiseAt = cycleNum; irqOnPhase = PH_NONE;
    end else IRQ = 1'b0;
    if (cycleNum == irqRaiseAt + IRQ_SYNC + 1) modelPend = 1'b1;
    #1;
    checkOutput($sformatf("ctl_%s", ph.name()), 32'(obsCtl()), 32'(expectCtl(ph, rdy, curOp, curFunct)));
    checkOutput($sformatf("state_%s", ph.name()), 32'(state), 32'(ph));
    checkOutput("bus_err", 32'(bus_err), 32'(modelBusErr));
    checkOutput("undef", 32'(UndefinedInst), 32'(classify(curOp, curFunct) == C_UNDEF));
  endtask

  task automatic step(input phaseT ph);
    applyStimulus(ph, 1'($urandom));
  endtask

  task automatic memPhase(input phaseT ph, input int waits, output logic ok);
    ok = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      if (i >= waits) begin
        applyStimulus(ph, 1'b1);
        break;
      end
      applyStimulus(ph, 1'b0);
      if (MEM_TIMEOUT != 0 && i == MEM_TIMEOUT) begin
        ok = 1'b0;
        modelBusErr = 1'b1;
        break;
      end
    end
  endtask

  // Expected cycle sequence of one instruction, derived from its class and memory wait counts.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fetchWaits,
                          input int memWaits);
    logic  ok;
    classT c;
    curOp = op; curFunct = fn;
    c = classify(op, fn);
    memPhase(PH_FETCH, fetchWaits, ok);
    if (!ok) begin step(PH_EXCEPT); return; end
    step(PH_DECODE);
    if (c == C_UNDEF) step(PH_EXCEPT);
    else if (modelPend) begin step(PH_IRQ); modelPend = 1'b0; end
    else case (c)
      C_LW: begin
        step(PH_MEM_ADDR);
        memPhase(PH_MEM_RD, memWaits, ok);
        if (ok) step(PH_WB_MEM); else step(PH_EXCEPT);
      end
      C_SW: begin
        step(PH_MEM_ADDR);
        memPhase(PH_MEM_WR, memWaits, ok);
        if (!ok) step(PH_EXCEPT);
      end
      C_BR:    step(PH_BRANCH);
      C_JMP:   step(PH_JUMP);
      C_RALU:  begin step(PH_EXEC_R); step(PH_WB_ALU); end
      C_IALU:  begin step(PH_EXEC_I); step(PH_WB_ALU); end
      default: ;
    endcase
  endtask

  task automatic applyReset();
    reset = 1'b0; IRQ = 1'b0; mem_ready = 1'b1;
    modelPend = 1'b0; modelBusErr = 1'b0; irqOnPhase = PH_NONE; irqRaiseAt = -100;
    #1;
    checkIdle("rst_async");
    @(negedge clk); #1;
    checkIdle("rst_hold");
    reset = 1'b1; #1;
    checkIdle("rst_release");
  endtask

  function automatic logic [11:0] pickInstr(int unsigned k);
    logic [5:0] rf = 6'($urandom);
    case (k)
      0: return {6'h00, 6'h00};  1: return {6'h00, 6'h02};  2: return {6'h00, 6'h03};
      3: return {6'h00, 6'h08};  4: return {6'h00, 6'h09};  5: return {6'h00, 6'h20};
      6: return {6'h00, 6'h21};  7: return {6'h00, 6'h22};  8: return {6'h00, 6'h23};
      9: return {6'h00, 6'h24}; 10: return {6'h00, 6'h25}; 11: return {6'h00, 6'h26};
      12: return {6'h00, 6'h27}; 13: return {6'h00, 6'h2a}; 14: return {6'h00, 6'h2b};
      15: return {6'h01, rf}; 16: return {6'h02, rf}; 17: return {6'h03, rf};
      18: return {6'h04, rf}; 19: return {6'h05, rf}; 20: return {6'h06, rf};
      21: return {6'h07, rf}; 22: return {6'h08, rf}; 23: return {6'h09, rf};
      24: return {6'h0a, rf}; 25: return {6'h0b, rf}; 26: return {6'h0c, rf};
      27: return {6'h0d, rf}; 28: return {6'h0f, rf}; 29: return {6'h23, rf};
      30: return {6'h2b, rf}; 31: return {6'h10, rf}; 32: return {6'h00, 6'h01};
      33: return {6'h0e, rf}; default: return {6'h3f, rf};
    endcase
  endfunction

  function automatic int randWaits();
    int unsigned r = $urandom_range(0, 31);
    if (r == 0) return MEM_TIMEOUT + 1;
    if (r == 1) return MEM_TIMEOUT;
    return int'(r % 4);
  endfunction

  initial begin
    logic [11:0] ins;
    reset = 1'b0; IRQ = 1'b0; mem_ready = 1'b1; OpCode = 6'h00; Funct = 6'h00;

    applyReset();
    runInstr(6'h00, 6'h20, 0, 0);                 // add
    runInstr(6'h23, 6'h00, 0, 3);                 // lw with three wait cycles in MEM_RD
    runInstr(6'h2b, 6'h00, 1, 2);                 // sw
    runInstr(6'h04, 6'h00, 0, 0);                 // beq
    runInstr(6'h02, 6'h00, 0, 0);                 // j
    runInstr(6'h03, 6'h00, 0, 0);                 // jal
    runInstr(6'h00, 6'h08, 0, 0);                 // jr
    runInstr(6'h00, 6'h09, 0, 0);                 // jalr
    runInstr(6'h00, 6'h02, 0, 0);                 // srl
    runInstr(6'h09, 6'h11, 0, 0);                 // addiu
    runInstr(6'h0f, 6'h00, 0, 0);                 // lui
    runInstr(6'h08, 6'h00, 0, 0);                 // addi

    // IRQ arriving mid-load is held until the following instruction's decode.
    irqOnPhase = PH_MEM_RD;
    runInstr(6'h23, 6'h00, 0, 3);
    runInstr(6'h00, 6'h20, 0, 0);

    // Undefined opcode outranks a pending IRQ, which is then taken next time round.
    irqOnPhase = PH_FETCH;
    runInstr(6'h10, 6'h00, 3, 0);
    runInstr(6'h00, 6'h21, 0, 0);
    runInstr(6'h00, 6'h21, 0, 0);

    runInstr(6'h00, 6'h25, MEM_TIMEOUT, 0);       // ready on the limit cycle still succeeds
    runInstr(6'h00, 6'h25, MEM_TIMEOUT + 1, 0);   // fetch timeout
    runInstr(6'h00, 6'h20, 0, 0);                 // bus_err stays set
    runInstr(6'h23, 6'h00, 0, MEM_TIMEOUT + 1);   // load timeout

    // Reset in the middle of a read must drop MemRead without waiting for a clock.
    curOp = 6'h23; curFunct = 6'h00;
    step(PH_FETCH); step(PH_DECODE); step(PH_MEM_ADDR);
    applyStimulus(PH_MEM_RD, 1'b0);
    applyStimulus(PH_MEM_RD, 1'b0);
    #2;
    applyReset();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0 && !modelPend && irqOnPhase == PH_NONE &&
          cycleNum > irqRaiseAt + 6) begin
        case ($urandom_range(0, 2))
          0: irqOnPhase = PH_FETCH;
          1: irqOnPhase = PH_DECODE;
          default: irqOnPhase = PH_MEM_RD;
        endcase
      end
      ins = pickInstr($urandom_range(0, 34));
      runInstr(ins[11:6], ins[5:0], randWaits(), randWaits());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
